// File: rtl/wormhole_output_arbiter_pkg.sv
// wormhole_output_arbiter_pkg: shared sizing helpers and flit-type field layout for the router.
package wormhole_output_arbiter_pkg;
    localparam int P_DEF       = 5;
    localparam int CREDITS_DEF = 4;
    localparam int FT_LO       = 32;
    localparam int FT_HI       = 33;

    typedef enum logic [1:0] {
        FT_BODY   = 2'b00,
        FT_HEAD   = 2'b01,
        FT_TAIL   = 2'b10,
        FT_SINGLE = 2'b11
    } flit_type_e;

    function automatic int log2c(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r == 0) ? 1 : r;
    endfunction

    function automatic logic ft_is_head(input flit_type_e ft);
        return ft[0];
    endfunction

    function automatic logic ft_is_tail(input flit_type_e ft);
        return ft[1];
    endfunction
endpackage

// File: rtl/wormhole_output_arbiter_if.sv
// wormhole_output_arbiter_if: request/grant/credit bundle between input VCs, arbiter and crossbar.
interface wormhole_output_arbiter_if
    import wormhole_output_arbiter_pkg::*;
#(
    parameter int P  = P_DEF,
    parameter int PW = log2c(P_DEF),
    parameter int CW = log2c(CREDITS_DEF + 1)
);
    logic [P-1:0]  req;
    logic [P-1:0]  head;
    logic [P-1:0]  tail;
    logic          credit_in;
    logic [P-1:0]  grant;
    logic [PW-1:0] grant_bin;
    logic          xfer;
    logic          busy;
    logic [CW-1:0] credits;

    modport master (
        output req, head, tail, credit_in,
        input  grant, grant_bin, xfer, busy, credits
    );

    modport slave (
        input  req, head, tail, credit_in,
        output grant, grant_bin, xfer, busy, credits
    );
endinterface

// File: rtl/wormhole_output_arbiter_rr_picker.sv
// wormhole_output_arbiter_rr_picker: first set candidate at or after ptr, wrapping at P.
module wormhole_output_arbiter_rr_picker #(
    parameter int P  = 5,
    parameter int PW = 3
) (
    input  logic [P-1:0]  cand_i,
    input  logic [PW-1:0] ptr_i,
    output logic [PW-1:0] win_o,
    output logic          any_o
);
    logic [P-1:0]  rot;
    logic [PW-1:0] off;
    logic [PW:0]   sum;

    // rotate so ptr lands on bit 0, fixed priority from bit 0, then add ptr back modulo P
    always_comb begin
        rot = P'({cand_i, cand_i} >> ptr_i);
        off = '0;
        for (int i = P - 1; i >= 0; i--) if (rot[i]) off = PW'(i);
        sum   = {1'b0, off} + {1'b0, ptr_i};
        win_o = (sum >= (PW+1)'(P)) ? PW'(sum - (PW+1)'(P)) : sum[PW-1:0];
        any_o = |cand_i;
    end
endmodule

// File: rtl/wormhole_output_arbiter.sv
// wormhole_output_arbiter: packet-granular round-robin lock of one output port with downstream credits.
module wormhole_output_arbiter
    import wormhole_output_arbiter_pkg::*;
#(
    parameter int P       = P_DEF,
    parameter int CREDITS = CREDITS_DEF
) (
    input logic                     clk,
    input logic                     reset_n,
    wormhole_output_arbiter_if.slave bus
);
    localparam int PW = log2c(P);
    localparam int CW = log2c(CREDITS + 1);

    typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] owner_q, owner_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] win;
    logic          any;
    logic          xfer;

    wormhole_output_arbiter_rr_picker #(.P(P), .PW(PW)) u_pick (
        .cand_i (bus.req & bus.head),
        .ptr_i  (ptr_q),
        .win_o  (win),
        .any_o  (any)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= CW'(CREDITS);
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        xfer    = (state_q == LOCK) && bus.req[owner_q] && (cnt_q != '0);
        if (state_q == IDLE && any) begin
            state_d = LOCK;
            owner_d = win;
        end
        if (xfer && bus.tail[owner_q]) begin
            state_d = IDLE;
            ptr_d   = (owner_q == PW'(P - 1)) ? '0 : owner_q + PW'(1);
        end
        // a credit returned while already full is dropped rather than wrapping
        cnt_d = (bus.credit_in && !xfer && cnt_q == CW'(CREDITS)) ? cnt_q
              : cnt_q + CW'(bus.credit_in) - CW'(xfer);
    end

    assign bus.xfer      = xfer;
    assign bus.busy      = (state_q == LOCK);
    assign bus.grant_bin = (state_q == LOCK) ? owner_q : '0;
    assign bus.grant     = xfer ? P'(1) << owner_q : '0;
    assign bus.credits   = cnt_q;
endmodule

// File: tb/tb_wormhole_output_arbiter.sv
// tb_wormhole_output_arbiter: packet-level reference model feeding a per-cycle scoreboard.
module tb_wormhole_output_arbiter;
    import wormhole_output_arbiter_pkg::*;

    localparam int P       = 5;
    localparam int CREDITS = 4;
    localparam int PW      = log2c(P);
    localparam int CW      = log2c(CREDITS + 1);

    typedef struct {
        int busy;
        int xfer;
        int gbin;
        int grant;
        int credits;
    } exp_t;

    logic clk;
    logic reset_n;
    int   errors = 0;
    int   checks = 0;
    bit   done   = 0;
    exp_t sb[$];

    int m_lock, m_owner, m_ptr, m_cnt;
    int plen[P];
    int pidx[P];

    wormhole_output_arbiter_if #(.P(P), .PW(PW), .CW(CW)) bus ();

    wormhole_output_arbiter #(.P(P), .CREDITS(CREDITS)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (reset_n && !done) begin
            if (sb.size() == 0) begin
                chk("scoreboard_empty", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("busy", int'(bus.busy), e.busy);
                chk("xfer", int'(bus.xfer), e.xfer);
                chk("grant_bin", int'(bus.grant_bin), e.gbin);
                chk("grant", int'(bus.grant), e.grant);
                chk("credits", int'(bus.credits), e.credits);
            end
        end
    end

    always @(posedge clk) begin
        if (reset_n) begin
            assert (!(bus.credit_in && !bus.xfer && bus.credits == CW'(CREDITS)))
            else begin
                errors++;
                $display("FAIL credit_overflow at %0t: credit_in with full counter", $time);
            end
        end
    end

    function automatic void model_reset();
        m_lock  = 0;
        m_owner = 0;
        m_ptr   = 0;
        m_cnt   = CREDITS;
        for (int i = 0; i < P; i++) begin
            plen[i] = 0;
            pidx[i] = 0;
        end
    endfunction

    // one clock of stimulus; the expectation for this cycle is pushed, then the model advances
    task automatic cycle(input logic [P-1:0] r, input logic [P-1:0] h, input logic [P-1:0] t,
                         input logic c, output logic x, output int who);
        exp_t e;
        bit   found;
        int   j;
        @(posedge clk);
        #1;
        bus.req       = r;
        bus.head      = h;
        bus.tail      = t;
        bus.credit_in = c;
        who       = m_owner;
        x         = (m_lock != 0) && r[m_owner] && (m_cnt > 0);
        e.busy    = m_lock;
        e.xfer    = int'(x);
        e.gbin    = m_lock ? m_owner : 0;
        e.grant   = x ? (1 << m_owner) : 0;
        e.credits = m_cnt;
        sb.push_back(e);
        if (!(c && !x && m_cnt == CREDITS)) m_cnt = m_cnt + int'(c) - int'(x);
        if (m_lock != 0) begin
            if (x && t[m_owner]) begin
                m_lock = 0;
                m_ptr  = (m_owner + 1) % P;
            end
        end else begin
            found = 0;
            for (int k = 0; k < P; k++) begin
                j = (m_ptr + k) % P;
                if (!found && r[j] && h[j]) begin
                    found   = 1;
                    m_lock  = 1;
                    m_owner = j;
                end
            end
        end
    endtask

    // upstream packet sources: each input holds its current flit until it is transferred
    task automatic traffic(input int n, input logic [P-1:0] mask, input int len,
                           input int pres, input int cr);
        logic [P-1:0] r, h, t;
        logic         c, x;
        int           who;
        for (int k = 0; k < n; k++) begin
            for (int i = 0; i < P; i++) begin
                if (plen[i] == 0) plen[i] = (len > 0) ? len : int'($urandom_range(1, 4));
                r[i] = mask[i] && (int'($urandom_range(0, 99)) < pres);
                h[i] = r[i] && (pidx[i] == 0);
                t[i] = r[i] && (pidx[i] == plen[i] - 1);
            end
            c = (m_cnt < CREDITS) && (int'($urandom_range(0, 99)) < cr);
            cycle(r, h, t, c, x, who);
            if (x) begin
                pidx[who]++;
                if (pidx[who] == plen[who]) begin
                    pidx[who] = 0;
                    plen[who] = 0;
                end
            end
        end
    endtask

    // asserted between clock edges so the outputs must clear without a clock
    task automatic do_reset();
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_grant", int'(bus.grant), 0);
        chk("rst_xfer", int'(bus.xfer), 0);
        chk("rst_grant_bin", int'(bus.grant_bin), 0);
        chk("rst_credits", int'(bus.credits), CREDITS);
        bus.req       = '0;
        bus.head      = '0;
        bus.tail      = '0;
        bus.credit_in = 1'b0;
        model_reset();
        @(negedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        logic dx;
        int   dw;
        reset_n       = 1'b0;
        bus.req       = '0;
        bus.head      = '0;
        bus.tail      = '0;
        bus.credit_in = 1'b0;
        model_reset();
        #12;
        chk("init_busy", int'(bus.busy), 0);
        chk("init_grant", int'(bus.grant), 0);
        chk("init_xfer", int'(bus.xfer), 0);
        chk("init_grant_bin", int'(bus.grant_bin), 0);
        chk("init_credits", int'(bus.credits), CREDITS);
        @(negedge clk);
        #1;
        reset_n = 1'b1;

        // single-flit packet on input 2
        cycle(5'b00100, 5'b00100, 5'b00100, 1'b0, dx, dw);
        cycle(5'b00100, 5'b00100, 5'b00100, 1'b0, dx, dw);
        cycle(5'b00000, 5'b00000, 5'b00000, 1'b0, dx, dw);
        cycle(5'b01000, 5'b01000, 5'b01000, 1'b1, dx, dw);
        cycle(5'b00000, 5'b00000, 5'b00000, 1'b0, dx, dw);

        // lock hold with a competing head and an upstream bubble
        do_reset();
        cycle(5'b00010, 5'b00010, 5'b00000, 1'b0, dx, dw);
        cycle(5'b10010, 5'b10010, 5'b00000, 1'b0, dx, dw);
        cycle(5'b10010, 5'b10000, 5'b00000, 1'b0, dx, dw);
        cycle(5'b10000, 5'b10000, 5'b10000, 1'b0, dx, dw);
        cycle(5'b10000, 5'b10000, 5'b10000, 1'b0, dx, dw);
        cycle(5'b10010, 5'b10000, 5'b10010, 1'b0, dx, dw);
        cycle(5'b10000, 5'b10000, 5'b10000, 1'b0, dx, dw);
        cycle(5'b10000, 5'b10000, 5'b10000, 1'b0, dx, dw);
        cycle(5'b00000, 5'b00000, 5'b00000, 1'b0, dx, dw);

        // round-robin fairness between inputs 0 and 3
        do_reset();
        traffic(24, 5'b01001, 3, 100, 100);

        // credit exhaustion on a 6-flit packet, then single credit pulses
        do_reset();
        traffic(8, 5'b00010, 6, 100, 0);
        traffic(1, 5'b00010, 6, 100, 100);
        traffic(2, 5'b00010, 6, 100, 0);
        traffic(1, 5'b00010, 6, 100, 100);
        traffic(3, 5'b00010, 6, 100, 0);

        // simultaneous credit and xfer at cnt=2, then pointer wrap after owner 4
        do_reset();
        traffic(3, 5'b10000, 3, 100, 0);
        traffic(1, 5'b10000, 3, 100, 100);
        traffic(6, 5'b01001, 1, 100, 0);

        // async reset while locked mid-packet
        do_reset();
        traffic(3, 5'b00100, 4, 100, 0);
        do_reset();

        // random traffic on all inputs
        traffic(3000, 5'b11111, 0, 75, 50);
        do_reset();
        traffic(1000, 5'b11111, 0, 90, 30);

        @(negedge clk);
        #1;
        done = 1;
        chk("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
